// File: rtl/ab_parallel_merge.sv
// ab_parallel_merge: merges policy_a/policy_b enforced A/B outputs (AND),
// watches for divergence with an AGREE/DIVERGE/LOCKOUT FSM, and logs
// recovery refs in a small FIFO drained by a valid/ready handshake.
// Ports: clk, reset (sync, active-high); A/B_ctp_policy_a/b in;
//   ab_policy_a/b_recovery_ref[1:0] in; A/B_ctp_final, merge_state[1:0],
//   fault, conflict_count[CNT_W-1:0] out; log_valid, log_data[3:0] out,
//   log_ready in; log_overflow out (sticky).
// Option: define AB_MERGE_STATS_EN to add rec_count_a/rec_count_b outputs.
module ab_parallel_merge #(
    parameter int DIVERGE_LIMIT = 4,
    parameter int RESYNC_CYCLES = 3,
    parameter int LOG_DEPTH     = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A_ctp_policy_a,
    input  logic             B_ctp_policy_a,
    input  logic             A_ctp_policy_b,
    input  logic             B_ctp_policy_b,
    input  logic [1:0]       ab_policy_a_recovery_ref,
    input  logic [1:0]       ab_policy_b_recovery_ref,
    output logic             A_ctp_final,
    output logic             B_ctp_final,
    output logic [1:0]       merge_state,
    output logic             fault,
    output logic [CNT_W-1:0] conflict_count,
    output logic             log_valid,
    output logic [3:0]       log_data,
    input  logic             log_ready,
    output logic             log_overflow
`ifdef AB_MERGE_STATS_EN
    ,
    output logic [CNT_W-1:0] rec_count_a,
    output logic [CNT_W-1:0] rec_count_b
`endif
);

    localparam int DW = $clog2(DIVERGE_LIMIT + 1);
    localparam int SW = $clog2(RESYNC_CYCLES + 1);
    localparam int AW = $clog2(LOG_DEPTH);

    typedef enum logic [1:0] {
        AGREE   = 2'd0,
        DIVERGE = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [SW-1:0] sync_cnt;
    logic          dis;

    assign dis = (A_ctp_policy_a != A_ctp_policy_b)
               | (B_ctp_policy_a != B_ctp_policy_b);

    assign merge_state = state;
    assign fault       = (state == LOCKOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= AGREE;
            div_cnt        <= '0;
            sync_cnt       <= '0;
            A_ctp_final    <= 1'b0;
            B_ctp_final    <= 1'b0;
            conflict_count <= '0;
        end else begin
            A_ctp_final <= (state != LOCKOUT) & A_ctp_policy_a & A_ctp_policy_b;
            B_ctp_final <= (state != LOCKOUT) & B_ctp_policy_a & B_ctp_policy_b;
            if (dis && conflict_count != {CNT_W{1'b1}})
                conflict_count <= conflict_count + 1'b1;
            unique case (state)
                AGREE: begin
                    if (dis) begin
                        if (DIVERGE_LIMIT == 1) begin
                            state    <= LOCKOUT;
                            sync_cnt <= '0;
                        end else begin
                            state   <= DIVERGE;
                            div_cnt <= DW'(1);
                        end
                    end
                end
                DIVERGE: begin
                    if (!dis) begin
                        state   <= AGREE;
                        div_cnt <= '0;
                    end else if (div_cnt == DW'(DIVERGE_LIMIT - 1)) begin
                        state    <= LOCKOUT;
                        div_cnt  <= '0;
                        sync_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LOCKOUT: begin
                    // Any disagreement restarts the resync window.
                    if (dis) begin
                        sync_cnt <= '0;
                    end else if (sync_cnt == SW'(RESYNC_CYCLES - 1)) begin
                        state    <= AGREE;
                        sync_cnt <= '0;
                    end else begin
                        sync_cnt <= sync_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= AGREE;
                end
            endcase
        end
    end

    // Recovery log FIFO
    logic [3:0]    mem [LOG_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;

    assign push_req  = (ab_policy_a_recovery_ref != 2'd0)
                     | (ab_policy_b_recovery_ref != 2'd0);
    assign log_valid = (count != '0);
    assign full      = (count == (AW + 1)'(LOG_DEPTH));
    assign pop       = log_valid & log_ready;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push      = push_req & (!full | pop);
    assign log_data  = log_valid ? mem[rd_ptr] : 4'd0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {ab_policy_a_recovery_ref, ab_policy_b_recovery_ref};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop)
                log_overflow <= 1'b1;
        end
    end

`ifdef AB_MERGE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_count_a <= '0;
            rec_count_b <= '0;
        end else begin
            if (ab_policy_a_recovery_ref != 2'd0 && rec_count_a != {CNT_W{1'b1}})
                rec_count_a <= rec_count_a + 1'b1;
            if (ab_policy_b_recovery_ref != 2'd0 && rec_count_b != {CNT_W{1'b1}})
                rec_count_b <= rec_count_b + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ab_parallel_merge.sv
// tb_ab_parallel_merge: directed bench for ab_parallel_merge with
// hand-computed expectations (DIVERGE_LIMIT=4, RESYNC_CYCLES=3, LOG_DEPTH=4).
module tb_ab_parallel_merge;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_a, b_a, a_b, b_b;
    logic [1:0] ref_a, ref_b;
    logic       A_ctp_final, B_ctp_final;
    logic [1:0] merge_state;
    logic       fault;
    logic [7:0] conflict_count;
    logic       log_valid;
    logic [3:0] log_data;
    logic       log_ready;
    logic       log_overflow;
`ifdef AB_MERGE_STATS_EN
    logic [7:0] rec_count_a, rec_count_b;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ab_parallel_merge #(
        .DIVERGE_LIMIT(4),
        .RESYNC_CYCLES(3),
        .LOG_DEPTH(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .A_ctp_policy_a(a_a),
        .B_ctp_policy_a(b_a),
        .A_ctp_policy_b(a_b),
        .B_ctp_policy_b(b_b),
        .ab_policy_a_recovery_ref(ref_a),
        .ab_policy_b_recovery_ref(ref_b),
        .A_ctp_final(A_ctp_final),
        .B_ctp_final(B_ctp_final),
        .merge_state(merge_state),
        .fault(fault),
        .conflict_count(conflict_count),
        .log_valid(log_valid),
        .log_data(log_data),
        .log_ready(log_ready),
        .log_overflow(log_overflow)
`ifdef AB_MERGE_STATS_EN
        ,
        .rec_count_a(rec_count_a),
        .rec_count_b(rec_count_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic aa, input logic ba,
                         input logic ab, input logic bb);
        a_a = aa;
        b_a = ba;
        a_b = ab;
        b_b = bb;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        ref_a = 2'd0;
        ref_b = 2'd0;
        log_ready = 1'b0;
        tick(2);
        chk("rst_state", 32'(merge_state), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_afinal", 32'(A_ctp_final), 0);
        chk("rst_cc", 32'(conflict_count), 0);
        chk("rst_lvalid", 32'(log_valid), 0);
        chk("rst_ldata", 32'(log_data), 0);
        chk("rst_ovf", 32'(log_overflow), 0);
        reset = 1'b0;

        // agree path
        drive(1, 0, 1, 0);
        tick();
        chk("agree_a", 32'(A_ctp_final), 1);
        chk("agree_b", 32'(B_ctp_final), 0);
        chk("agree_state", 32'(merge_state), 0);
        chk("agree_cc", 32'(conflict_count), 0);
        drive(1, 1, 1, 1);
        tick();
        chk("agree11_b", 32'(B_ctp_final), 1);

        // short glitch: 2 disagree cycles then agree
        drive(1, 0, 0, 0);
        tick();
        chk("glitch1_state", 32'(merge_state), 1);
        chk("glitch1_a", 32'(A_ctp_final), 0);
        tick();
        chk("glitch2_state", 32'(merge_state), 1);
        drive(0, 0, 0, 0);
        tick();
        chk("glitch_back", 32'(merge_state), 0);
        chk("glitch_fault", 32'(fault), 0);
        chk("glitch_cc", 32'(conflict_count), 2);

        // divergence: 4 disagree cycles -> LOCKOUT
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("div_state", 32'(merge_state), 1);
            chk("div_fault", 32'(fault), 0);
        end
        tick();
        chk("lock_state", 32'(merge_state), 2);
        chk("lock_fault", 32'(fault), 1);
        chk("lock_cc", 32'(conflict_count), 6);

        // resync: agree 2, dis 1, agree 3
        drive(1, 1, 1, 1);
        tick();
        chk("lock_finals_off", 32'(A_ctp_final), 0);
        chk("rs1_state", 32'(merge_state), 2);
        tick();
        chk("rs2_state", 32'(merge_state), 2);
        drive(1, 1, 0, 1);
        tick();
        chk("rs_dis_state", 32'(merge_state), 2);
        chk("rs_dis_cc", 32'(conflict_count), 7);
        drive(1, 1, 1, 1);
        tick(2);
        chk("rs_hold", 32'(merge_state), 2);
        chk("rs_hold_fault", 32'(fault), 1);
        tick();
        chk("rs_agree", 32'(merge_state), 0);
        chk("rs_fault", 32'(fault), 0);
        chk("rs_last_off", 32'(B_ctp_final), 0);
        tick();
        chk("rs_follow_a", 32'(A_ctp_final), 1);
        chk("rs_follow_b", 32'(B_ctp_final), 1);
        drive(0, 1, 0, 1);
        tick();
        chk("rs_pat_a", 32'(A_ctp_final), 0);
        chk("rs_pat_b", 32'(B_ctp_final), 1);

        // recovery log: fill, overflow, pop+push on full, drain
        ref_a = 2'd1;
        tick();
        chk("log_vis", 32'(log_valid), 1);
        chk("log_head", 32'(log_data), 32'h4);
        tick(3);
        chk("log_full_noovf", 32'(log_overflow), 0);
        tick();
        chk("log_ovf", 32'(log_overflow), 1);
        chk("log_full_head", 32'(log_data), 32'h4);
        ref_a = 2'd2;
        ref_b = 2'd3;
        log_ready = 1'b1;
        tick();
        chk("pp_valid", 32'(log_valid), 1);
        chk("pp_head", 32'(log_data), 32'h4);
        ref_a = 2'd0;
        ref_b = 2'd0;
        tick();
        chk("drain1", 32'(log_data), 32'h4);
        tick();
        chk("drain2", 32'(log_data), 32'h4);
        tick();
        chk("drain3", 32'(log_data), 32'hB);
        tick();
        chk("drain_empty_v", 32'(log_valid), 0);
        chk("drain_empty_d", 32'(log_data), 0);
        tick();
        chk("empty_pop_ign", 32'(log_valid), 0);
        chk("ovf_sticky", 32'(log_overflow), 1);

        // reset in LOCKOUT with 3 log entries
        log_ready = 1'b0;
        drive(1, 0, 0, 0);
        ref_b = 2'd1;
        tick(3);
        ref_b = 2'd0;
        tick();
        chk("r6_lock", 32'(merge_state), 2);
        chk("r6_head", 32'(log_data), 32'h1);
        chk("r6_cc", 32'(conflict_count), 11);
`ifdef AB_MERGE_STATS_EN
        chk("stats_a", 32'(rec_count_a), 6);
        chk("stats_b", 32'(rec_count_b), 4);
`endif
        reset = 1'b1;
        tick();
        chk("r6_state", 32'(merge_state), 0);
        chk("r6_fault", 32'(fault), 0);
        chk("r6_lvalid", 32'(log_valid), 0);
        chk("r6_ovf", 32'(log_overflow), 0);
        chk("r6_cc0", 32'(conflict_count), 0);
`ifdef AB_MERGE_STATS_EN
        chk("r6_stats_a", 32'(rec_count_a), 0);
`endif
        reset = 1'b0;

        // conflict counter saturation
        drive(0, 1, 0, 0);
        tick(300);
        chk("cc_sat", 32'(conflict_count), 255);
        chk("sat_lock", 32'(merge_state), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
